// File: rtl/e1_pkg.sv
// Shared E1 CRC-4 multiframe constants, bit-position decode and CRC step.
package e1_pkg;

  localparam logic [3:0] CRC4_POLY       = 4'h3;   // x^4 + x + 1, x^4 term implicit
  localparam logic [3:0] CRC4_INIT       = 4'h0;
  localparam logic [4:0] TS0             = 5'd0;
  localparam logic [4:0] TS_LAST         = 5'd31;
  localparam logic [2:0] BIT_FIRST       = 3'd0;
  localparam logic [2:0] BIT_LAST        = 3'd7;
  localparam logic [2:0] SMF_FRAME_FIRST = 3'd0;
  localparam logic [2:0] SMF_FRAME_LAST  = 3'd7;
  localparam logic [2:0] CBIT_FRAME_LAST = 3'd6;   // frame carrying C4 within an SMF
  localparam logic [3:0] EBIT_FRAME_A    = 4'd13;
  localparam logic [3:0] EBIT_FRAME_B    = 4'd15;

  typedef struct packed {
    logic sof;
    logic eof;
    logic cpos;
    logic epos;
  } e1_pos_t;

  // C-bits sit in the even frames of each SMF (0/2/4/6 and 8/10/12/14).
  function automatic logic is_cbit_frame(input logic [2:0] f);
    return ~f[0];
  endfunction

  function automatic e1_pos_t decode_pos(input logic [3:0] frame,
                                         input logic [4:0] ts,
                                         input logic [2:0] bitpos);
    e1_pos_t p;
    logic    first_bit;
    first_bit = (ts == TS0) && (bitpos == BIT_FIRST);
    p         = '0;
    p.sof     = first_bit && (frame[2:0] == SMF_FRAME_FIRST);
    p.eof     = (frame[2:0] == SMF_FRAME_LAST) && (ts == TS_LAST) && (bitpos == BIT_LAST);
    p.cpos    = first_bit && is_cbit_frame(frame[2:0]);
    p.epos    = first_bit && ((frame == EBIT_FRAME_A) || (frame == EBIT_FRAME_B));
    return p;
  endfunction

  // One serial step of the direct-form CRC: remainder of M(x)*x^4 / G(x).
  function automatic logic [3:0] crc4_step(input logic [3:0] crc,
                                           input logic       din,
                                           input logic [3:0] poly);
    logic fb;
    fb = crc[3] ^ din;
    return {crc[2:0], 1'b0} ^ (fb ? poly : 4'h0);
  endfunction

endpackage

// File: rtl/e1_crc4.sv
// Serial CRC-4 engine; restarts from INIT on the first bit of each SMF.
module e1_crc4
  import e1_pkg::*;
#(
  parameter logic [3:0] INIT = 4'h0,
  parameter logic [3:0] POLY = 4'h3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_bit,
  input  logic       i_first,
  input  logic       i_valid,
  output logic [3:0] o_crc
);

  logic [3:0] r_crc;
  logic [3:0] w_seed;

  assign w_seed = i_first ? INIT : r_crc;

  // Advance the remainder by one bit per valid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= '0;
    end else if (i_valid) begin
      r_crc <= crc4_step(w_seed, i_bit, POLY);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/e1_rx_crc4_check.sv
// Receive CRC-4 multiframe checker: feeds the CRC engine per SMF, captures
// C-bits/E-bits, checks each SMF against the next SMF's C-bits, and keeps
// error counter plus per-window CRC loss alarm.
module e1_rx_crc4_check
  import e1_pkg::*;
#(
  parameter int          ERR_CNT_W  = 16,
  parameter int unsigned WIN_LEN    = 1000,
  parameter int unsigned WIN_THRESH = 915
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_bit,
  input  logic                 in_valid,
  input  logic [3:0]           in_frame,
  input  logic [4:0]           in_ts,
  input  logic [2:0]           in_bitpos,
  input  logic                 in_mf_lock,
  output logic                 smf_ok,
  output logic                 smf_err,
  output logic [1:0]           ebit_tx,
  output logic                 rem_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_cnt_clr,
  output logic                 crc_alarm
);

  localparam int WIN_W = $clog2(WIN_LEN + 1);

  e1_pos_t              w_pos;
  logic                 w_q;
  logic                 w_sof;
  logic                 w_eof;
  logic                 w_cpos;
  logic                 w_epos;
  logic                 w_eng_bit;
  logic [3:0]           w_crc;
  logic [3:0]           w_c_next;
  logic                 w_chk;
  logic                 w_match;
  logic                 w_chk_done;
  logic [WIN_W-1:0]     w_win_cnt_nx;
  logic [WIN_W-1:0]     w_win_err_nx;

  logic                 r_smf_full;
  logic                 r_snap_pend;
  logic                 r_eof_half;
  logic [3:0]           r_crc_prev;
  logic                 r_prev_ok;
  logic                 r_prev_half;
  logic [3:0]           r_rx_c;
  logic                 r_smf_ok;
  logic                 r_smf_err;
  logic                 r_rem_err;
  logic [1:0]           r_ebit;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [WIN_W-1:0]     r_win_cnt;
  logic [WIN_W-1:0]     r_win_err;
  logic                 r_alarm;

  assign w_pos     = decode_pos(in_frame, in_ts, in_bitpos);
  assign w_q       = in_valid & in_mf_lock;
  assign w_sof     = w_q & w_pos.sof;
  assign w_eof     = w_q & w_pos.eof;
  assign w_cpos    = w_q & w_pos.cpos;
  assign w_epos    = w_q & w_pos.epos;
  assign w_eng_bit = in_bit & ~w_pos.cpos;

  // C4 is compared in the same edge it is captured, giving 1-cycle latency.
  assign w_c_next  = {r_rx_c[2:0], in_bit};
  assign w_chk     = w_cpos && (in_frame[2:0] == CBIT_FRAME_LAST) && r_prev_ok;
  assign w_match   = (w_c_next == r_crc_prev);

  e1_crc4 #(
    .INIT (CRC4_INIT),
    .POLY (CRC4_POLY)
  ) u_crc4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_bit   (w_eng_bit),
    .i_first (w_sof),
    .i_valid (w_q),
    .o_crc   (w_crc)
  );

  // SMF tracking, snapshot of the finished SMF's CRC, C-bit capture and check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smf_full  <= 1'b0;
      r_snap_pend <= 1'b0;
      r_eof_half  <= 1'b0;
      r_crc_prev  <= '0;
      r_prev_ok   <= 1'b0;
      r_prev_half <= 1'b0;
      r_rx_c      <= '0;
      r_smf_ok    <= 1'b0;
      r_smf_err   <= 1'b0;
      r_rem_err   <= 1'b0;
      r_ebit      <= 2'b11;
    end else begin
      r_smf_ok  <= 1'b0;
      r_smf_err <= 1'b0;
      r_rem_err <= w_epos & ~in_bit;
      if (!in_mf_lock) begin
        r_smf_full  <= 1'b0;
        r_snap_pend <= 1'b0;
        r_prev_ok   <= 1'b0;
        r_rx_c      <= '0;
        r_ebit      <= 2'b11;
      end else begin
        if (w_sof) begin
          r_smf_full <= 1'b1;
        end
        // Engine already holds the eof bit here; a coinciding sof only
        // affects the engine at this same edge, so the old value is safe.
        if (r_snap_pend) begin
          r_crc_prev  <= w_crc;
          r_prev_ok   <= 1'b1;
          r_prev_half <= r_eof_half;
          r_snap_pend <= 1'b0;
        end
        // An SMF entered mid-way after lock is never snapshotted.
        if (w_eof) begin
          r_snap_pend <= r_smf_full;
          r_eof_half  <= in_frame[3];
        end
        if (w_cpos) begin
          r_rx_c <= w_c_next;
        end
        if (w_chk) begin
          r_smf_ok             <= w_match;
          r_smf_err            <= ~w_match;
          r_ebit[r_prev_half]  <= w_match;
        end
      end
    end
  end

  // Saturating error counter; clear beats a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_cnt_clr) begin
      r_err_cnt <= '0;
    end else if (r_smf_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign w_chk_done   = r_smf_ok | r_smf_err;
  assign w_win_cnt_nx = r_win_cnt + WIN_W'(1);
  assign w_win_err_nx = r_win_err + WIN_W'(r_smf_err);

  // Window monitor: alarm re-evaluated only when a window of checks closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt <= '0;
      r_win_err <= '0;
      r_alarm   <= 1'b0;
    end else if (!in_mf_lock) begin
      r_win_cnt <= '0;
      r_win_err <= '0;
    end else if (w_chk_done) begin
      if (w_win_cnt_nx == WIN_W'(WIN_LEN)) begin
        r_alarm   <= (w_win_err_nx >= WIN_W'(WIN_THRESH));
        r_win_cnt <= '0;
        r_win_err <= '0;
      end else begin
        r_win_cnt <= w_win_cnt_nx;
        r_win_err <= w_win_err_nx;
      end
    end
  end

  assign smf_ok    = r_smf_ok;
  assign smf_err   = r_smf_err;
  assign rem_err   = r_rem_err;
  assign ebit_tx   = r_ebit;
  assign err_cnt   = r_err_cnt;
  assign crc_alarm = r_alarm;

endmodule

// File: tb/tb_e1_rx_crc4_check.sv
// Self-checking bench for e1_rx_crc4_check with a transaction-level model.
module tb_e1_rx_crc4_check;

  localparam int ERR_W = 4;
  localparam int WLEN  = 10;
  localparam int WTHR  = 7;
  localparam int SAT   = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_bit = 1'b0;
  logic             in_valid = 1'b0;
  logic [3:0]       in_frame = '0;
  logic [4:0]       in_ts = '0;
  logic [2:0]       in_bitpos = '0;
  logic             in_mf_lock = 1'b0;
  logic             err_cnt_clr = 1'b0;
  logic             smf_ok, smf_err, rem_err, crc_alarm;
  logic [1:0]       ebit_tx;
  logic [ERR_W-1:0] err_cnt;

  e1_rx_crc4_check #(
    .ERR_CNT_W  (ERR_W),
    .WIN_LEN    (WLEN),
    .WIN_THRESH (WTHR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_bit      (in_bit),
    .in_valid    (in_valid),
    .in_frame    (in_frame),
    .in_ts       (in_ts),
    .in_bitpos   (in_bitpos),
    .in_mf_lock  (in_mf_lock),
    .smf_ok      (smf_ok),
    .smf_err     (smf_err),
    .ebit_tx     (ebit_tx),
    .rem_err     (rem_err),
    .err_cnt     (err_cnt),
    .err_cnt_clr (err_cnt_clr),
    .crc_alarm   (crc_alarm)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // CRC-4 by long division of the augmented message (M(x)*x^4) by x^4+x+1.
  function automatic logic [3:0] crc4_of(input bit msg[$]);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < msg.size() + 4; i++) begin
      r = {r[3:0], (i < msg.size()) ? msg[i] : 1'b0};
      if (r[4]) r = r ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  // Reference model state
  bit         m_full, m_prev_ok, m_prev_half;
  bit [3:0]   m_prev_crc;
  bit         m_cb[4];
  bit         m_msg[$];
  bit [1:0]   m_ebit;
  int         m_err_cnt, m_win_n, m_win_e;
  bit         m_alarm;
  bit         cur_ok, cur_err, cur_rem;
  int         obs_ok, obs_err, obs_rem;

  // Stimulus generator state
  logic [3:0] g_prev_crc = '0;
  logic       g_half = 1'b0;
  logic       clr_on_err = 1'b0;

  task automatic model_reset();
    m_full = 0; m_prev_ok = 0; m_prev_half = 0; m_prev_crc = 0;
    m_msg.delete();
    m_ebit = 2'b11; m_err_cnt = 0; m_alarm = 0; m_win_n = 0; m_win_e = 0;
    cur_ok = 0; cur_err = 0; cur_rem = 0;
  endtask

  task automatic step(input logic v, input logic lock, input logic b,
                      input logic [3:0] fr, input logic [4:0] ts, input logic [2:0] bp);
    logic nok, nerr, nrem, first_bit, sof, eof, cp, ep, match;
    nok = 0; nerr = 0; nrem = 0;
    in_valid = v; in_mf_lock = lock; in_bit = b;
    in_frame = fr; in_ts = ts; in_bitpos = bp;
    err_cnt_clr = clr_on_err & cur_err;

    if (err_cnt_clr) m_err_cnt = 0;
    else if (cur_err && m_err_cnt < SAT) m_err_cnt++;

    if (!lock) begin
      m_win_n = 0; m_win_e = 0;
    end else if (cur_ok || cur_err) begin
      m_win_n++;
      if (cur_err) m_win_e++;
      if (m_win_n == WLEN) begin
        m_alarm = (m_win_e >= WTHR);
        m_win_n = 0; m_win_e = 0;
      end
    end

    if (!lock) begin
      m_full = 0; m_prev_ok = 0; m_ebit = 2'b11; m_msg.delete();
    end else if (v) begin
      first_bit = (ts == 0) && (bp == 0);
      sof = first_bit && (fr[2:0] == 0);
      eof = (fr[2:0] == 7) && (ts == 31) && (bp == 7);
      cp  = first_bit && !fr[0];
      ep  = first_bit && ((fr == 13) || (fr == 15));
      if (sof) begin m_full = 1; m_msg.delete(); end
      m_msg.push_back(cp ? 1'b0 : b);
      if (cp) begin
        m_cb[fr[2:1]] = b;
        if (fr[2:0] == 6 && m_prev_ok) begin
          match = ({m_cb[0], m_cb[1], m_cb[2], m_cb[3]} == m_prev_crc);
          nok = match; nerr = !match;
          m_ebit[m_prev_half] = match;
        end
      end
      if (ep && !b) nrem = 1;
      if (eof && m_full) begin
        m_prev_crc = crc4_of(m_msg); m_prev_half = fr[3]; m_prev_ok = 1;
      end
    end

    @(posedge clk); #1;
    chk_eq("smf_ok",    32'(smf_ok),    32'(nok));
    chk_eq("smf_err",   32'(smf_err),   32'(nerr));
    chk_eq("rem_err",   32'(rem_err),   32'(nrem));
    chk_eq("ebit_tx",   32'(ebit_tx),   32'(m_ebit));
    chk_eq("err_cnt",   32'(err_cnt),   32'(m_err_cnt));
    chk_eq("crc_alarm", 32'(crc_alarm), 32'(m_alarm));
    obs_ok  += int'(smf_ok);
    obs_err += int'(smf_err);
    obs_rem += int'(rem_err);
    cur_ok = nok; cur_err = nerr; cur_rem = nrem;
  endtask

  task automatic idle(input int n, input logic lock);
    for (int i = 0; i < n; i++)
      step(lock ? 1'b0 : 1'($urandom), lock, 1'($urandom), 4'($urandom), 5'($urandom), 3'($urandom));
  endtask

  // Drives frames f_lo..f_hi of one SMF; C-bits carry the previous SMF's CRC ^ cflip.
  // Reduced rate presents only TS0, TS1 and TS31 with random idle gaps.
  task automatic send_smf(input logic half, input logic full_rate, input logic [3:0] cflip,
                          input logic e13, input logic e15, input int f_lo, input int f_hi);
    logic [3:0] cval, fr;
    logic       b;
    bit         q[$];
    cval = g_prev_crc ^ cflip;
    for (int f = f_lo; f <= f_hi; f++) begin
      fr = {half, 3'(f)};
      for (int ts = 0; ts < 32; ts++) begin
        if (!full_rate && ts != 0 && ts != 1 && ts != 31) continue;
        for (int bp = 0; bp < 8; bp++) begin
          b = 1'($urandom);
          if (ts == 0 && bp == 0) begin
            if (f % 2 == 0)      b = cval[3 - f / 2];
            else if (fr == 4'd13) b = e13;
            else if (fr == 4'd15) b = e15;
          end
          if (!full_rate)
            while ($urandom_range(0, 3) == 0)
              step(1'b0, 1'b1, 1'($urandom), 4'($urandom), 5'($urandom), 3'($urandom));
          step(1'b1, 1'b1, b, fr, 5'(ts), 3'(bp));
          q.push_back((ts == 0 && bp == 0 && f % 2 == 0) ? 1'b0 : b);
        end
      end
    end
    if (f_lo == 0 && f_hi == 7) g_prev_crc = crc4_of(q);
  endtask

  task automatic send_full(input logic [3:0] cflip, input logic e13, input logic e15);
    send_smf(g_half, 1'b0, cflip, e13, e15, 0, 7);
    g_half = ~g_half;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_mf_lock = 1'b0; in_valid = 1'b0; err_cnt_clr = 1'b0;
    #2;
    chk_eq("rst_smf_ok",  32'(smf_ok),    32'(0));
    chk_eq("rst_smf_err", 32'(smf_err),   32'(0));
    chk_eq("rst_rem_err", 32'(rem_err),   32'(0));
    chk_eq("rst_ebit",    32'(ebit_tx),   32'(3));
    chk_eq("rst_err_cnt", 32'(err_cnt),   32'(0));
    chk_eq("rst_alarm",   32'(crc_alarm), 32'(0));
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int base;
    model_reset();
    #2;
    do_reset();
    idle(3, 1'b0);

    // Full-rate, correct C-bits: 4 multiframes -> 7 checks, all ok
    base = obs_ok + obs_err;
    for (int i = 0; i < 8; i++) begin
      send_smf(g_half, 1'b1, 4'h0, 1'b1, 1'b1, 0, 7);
      g_half = ~g_half;
      if (i == 0) chk_eq("no_check_first_smf", 32'(obs_ok + obs_err - base), 32'(0));
    end
    chk_eq("good_ok_count",  32'(obs_ok + obs_err - base), 32'(7));
    chk_eq("good_err_count", 32'(obs_err), 32'(0));
    chk_eq("good_ebit",      32'(ebit_tx), 32'(3));

    // C2 flip in frame 10 -> SMF I check fails
    send_full(4'h0, 1'b1, 1'b1);
    base = obs_err;
    send_full(4'b0100, 1'b1, 1'b1);
    chk_eq("flip_err_count", 32'(obs_err - base), 32'(1));
    chk_eq("flip_ebit",      32'(ebit_tx), 32'(2'b10));
    chk_eq("flip_err_cnt",   32'(err_cnt), 32'(1));
    send_full(4'h0, 1'b1, 1'b1);
    send_full(4'h0, 1'b1, 1'b1);
    chk_eq("flip_restore_ebit", 32'(ebit_tx), 32'(3));

    // Remote E-bits: frame 13 = 0 pulses, frame 15 = 1 does not
    send_full(4'h0, 1'b1, 1'b1);
    base = obs_rem;
    send_full(4'h0, 1'b0, 1'b1);
    chk_eq("rem_err_count", 32'(obs_rem - base), 32'(1));

    // Reset in the middle of an SMF with ebit/err_cnt non-default
    send_full(4'h0, 1'b1, 1'b1);
    send_full(4'b0001, 1'b1, 1'b1);
    chk_eq("pre_rst_ebit", 32'(ebit_tx), 32'(2'b10));
    send_smf(g_half, 1'b0, 4'h0, 1'b1, 1'b1, 0, 3);
    do_reset();

    // Window 1: 10 checks, 7 errors -> alarm
    idle(4, 1'b0);
    send_full(4'h0, 1'b1, 1'b1);
    for (int k = 0; k < WLEN; k++)
      send_full((k < WTHR) ? 4'($urandom_range(1, 15)) : 4'h0, 1'b1, 1'b1);
    chk_eq("alarm_set", 32'(crc_alarm), 32'(1));

    // Lock drop at frame 3, re-lock mid-SMF
    send_smf(g_half, 1'b0, 4'h0, 1'b1, 1'b1, 0, 3);
    idle(5, 1'b0);
    send_smf(g_half, 1'b0, 4'h0, 1'b1, 1'b1, 5, 7);
    g_half = ~g_half;
    chk_eq("lock_alarm_hold",  32'(crc_alarm), 32'(1));
    chk_eq("lock_errcnt_hold", 32'(err_cnt),   32'(7));
    base = obs_ok + obs_err;
    send_full(4'h0, 1'b1, 1'b1);
    chk_eq("relock_first_nochk", 32'(obs_ok + obs_err - base), 32'(0));
    send_full(4'h0, 1'b1, 1'b1);
    chk_eq("relock_second_chk",  32'(obs_ok + obs_err - base), 32'(1));

    // Window 2: 10 checks, 6 errors -> alarm clears at close only
    idle(3, 1'b0);
    send_full(4'h0, 1'b1, 1'b1);
    for (int k = 0; k < WLEN; k++) begin
      send_full((k < WTHR - 1) ? 4'($urandom_range(1, 15)) : 4'h0, 1'b1, 1'b1);
      if (k == 4) chk_eq("alarm_hold_mid", 32'(crc_alarm), 32'(1));
    end
    chk_eq("alarm_clear", 32'(crc_alarm), 32'(0));

    // Saturation of the error counter
    for (int k = 0; k < 4; k++) send_full(4'h9, 1'b1, 1'b1);
    chk_eq("err_cnt_sat", 32'(err_cnt), 32'(SAT));

    // Clear coincident with smf_err wins
    clr_on_err = 1'b1;
    send_full(4'h8, 1'b1, 1'b1);
    clr_on_err = 1'b0;
    chk_eq("clr_wins",     32'(err_cnt), 32'(0));
    send_full(4'h1, 1'b1, 1'b1);
    chk_eq("post_clr_inc", 32'(err_cnt), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
